// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
// Shared constants and fetch FSM encoding for the VGA line-fetch pixel stage.
package vga_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int SRC_W_DEF = H_RES / 2;
  localparam int SRC_H_DEF = V_RES / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/line_buffer_dp.sv
`timescale 1ns/1ps
// Simple dual-port line store: one write port for VRAM returns, one registered
// read port for the display side, both on the pixel clock.
module line_buffer_dp #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately left out of reset so it maps onto block RAM;
  // its contents are only meaningful after a fetch has written them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_line_fetch.sv
`timescale 1ns/1ps
// Prefetches source lines from VRAM into ping-pong line buffers and emits 2x-scaled
// pixels, with hsync/vsync/DE delayed to match the two-cycle pixel latency.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int          SRC_W     = SRC_W_DEF,
  parameter int          SRC_H     = SRC_H_DEF,
  parameter int          PIX_W     = 8,
  parameter int          ADDR_W    = 17,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          MAX_OUT   = 4
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              i_hs,
  input  logic              i_vs,
  input  logic              i_de,
  input  logic              i_frame,
  input  logic [11:0]       i_h,
  input  logic [11:0]       i_v,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_addr,
  input  logic              i_gnt,
  input  logic              i_rvalid,
  input  logic [PIX_W-1:0]  i_rdata,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_de,
  output logic [PIX_W-1:0]  o_pixel,
  output logic              o_underrun
);

  localparam int X_W    = $clog2(SRC_W);
  localparam int BUF_AW = $clog2(2 * SRC_W);
  localparam int OUT_W  = $clog2(MAX_OUT + 1);

  fetch_state_e      state, state_nxt;
  logic [X_W-1:0]    req_x;
  logic [X_W-1:0]    wr_x;
  logic [OUT_W-1:0]  outstanding;
  logic [ADDR_W-1:0] row_base;
  logic              fetch_bank;

  logic              de_q, hs_q, vs_q;
  logic [10:0]       v_src;
  logic              de_rise, trig_frame, trig_line, trigger;
  logic              idle, start, accept, last_req, ret;

  logic [BUF_AW-1:0] wr_addr, rd_addr;
  logic [PIX_W-1:0]  rd_pixel;

  // ---------------------------------------------------------------------------
  // Trigger detection
  // ---------------------------------------------------------------------------
  assign v_src      = i_v[11:1];
  assign de_rise    = i_de & ~de_q;
  assign trig_frame = i_frame;
  // Even output line starts the prefetch of the next source line; the last
  // source line has no successor.
  assign trig_line  = de_rise & ~i_v[0] & (v_src < 11'(SRC_H - 1));
  assign trigger    = trig_frame | trig_line;

  assign idle     = (state == ST_IDLE);
  assign start    = trigger & idle;
  assign accept   = o_req & i_gnt;
  assign last_req = accept & (req_x == X_W'(SRC_W - 1));
  // Returns that arrive with nothing outstanding belong to a fetch killed by reset.
  assign ret      = i_rvalid & (outstanding != '0);

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (trigger)              state_nxt = ST_FETCH;
      ST_FETCH: if (last_req)             state_nxt = ST_DRAIN;
      ST_DRAIN: if (outstanding == '0)    state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req = 1'b0;
    if ((state == ST_FETCH) && (outstanding < OUT_W'(MAX_OUT))) begin
      o_req = 1'b1;
    end
  end

  assign o_addr = row_base + ADDR_W'(req_x);

  // ---------------------------------------------------------------------------
  // Request / return counters and row base
  // ---------------------------------------------------------------------------
  // NOTE: all state below updates with non-blocking assignments so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      req_x      <= '0;
      wr_x       <= '0;
      row_base   <= ADDR_W'(BASE_ADDR);
      fetch_bank <= 1'b0;
    end else if (start) begin
      req_x <= '0;
      wr_x  <= '0;
      if (trig_frame) begin
        row_base   <= ADDR_W'(BASE_ADDR);
        fetch_bank <= 1'b0;
      end else begin
        row_base   <= row_base + ADDR_W'(SRC_W);
        fetch_bank <= ~i_v[1];
      end
    end else begin
      if (accept) req_x <= req_x + 1'b1;
      if (ret)    wr_x  <= wr_x + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      outstanding <= '0;
    end else begin
      case ({accept, ret})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      o_underrun <= 1'b0;
    end else if (trigger && !idle) begin
      o_underrun <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: bank 0 at [0, SRC_W), bank 1 at [SRC_W, 2*SRC_W)
  // ---------------------------------------------------------------------------
  assign wr_addr = fetch_bank ? BUF_AW'(SRC_W) + BUF_AW'(wr_x) : BUF_AW'(wr_x);
  assign rd_addr = i_v[1] ? BUF_AW'(SRC_W) + BUF_AW'(i_h >> 1) : BUF_AW'(i_h >> 1);

  line_buffer_dp #(
    .DEPTH (2 * SRC_W),
    .WIDTH (PIX_W),
    .AW    (BUF_AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (ret),
    .waddr (wr_addr),
    .wdata (i_rdata),
    .raddr (rd_addr),
    .rdata (rd_pixel)
  );

  // ---------------------------------------------------------------------------
  // Display pipeline: stage 1 alongside the RAM read, stage 2 at the pins
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      o_hs    <= 1'b1;
      o_vs    <= 1'b1;
      o_de    <= 1'b0;
      o_pixel <= '0;
    end else begin
      hs_q    <= i_hs;
      vs_q    <= i_vs;
      de_q    <= i_de;
      o_hs    <= hs_q;
      o_vs    <= vs_q;
      o_de    <= de_q;
      o_pixel <= de_q ? rd_pixel : '0;
    end
  end

endmodule

// File: tb/tb_vga_line_fetch.sv
`timescale 1ns/1ps
// Scoreboard bench for vga_line_fetch: stimulus pushes expected VRAM addresses,
// syncs and pixels; a negedge monitor pops and compares against DUT outputs.
module tb_vga_line_fetch;

  localparam int SRC_W   = 320;
  localparam int PIX_W   = 8;
  localparam int ADDR_W  = 17;
  localparam int MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              nreset;
  logic              i_hs, i_vs, i_de, i_frame;
  logic [11:0]       i_h, i_v;
  logic              o_req;
  logic [ADDR_W-1:0] o_addr;
  logic              i_gnt;
  logic              i_rvalid = 1'b0;
  logic [PIX_W-1:0]  i_rdata  = '0;
  logic              o_hs, o_vs, o_de;
  logic [PIX_W-1:0]  o_pixel;
  logic              o_underrun;

  always #20 clk = ~clk;

  vga_line_fetch dut (
    .clk        (clk),
    .nreset     (nreset),
    .i_hs       (i_hs),
    .i_vs       (i_vs),
    .i_de       (i_de),
    .i_frame    (i_frame),
    .i_h        (i_h),
    .i_v        (i_v),
    .o_req      (o_req),
    .o_addr     (o_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .o_hs       (o_hs),
    .o_vs       (o_vs),
    .o_de       (o_de),
    .o_pixel    (o_pixel),
    .o_underrun (o_underrun)
  );

  typedef struct packed { logic hs; logic vs; logic de; } sync_t;
  typedef struct packed { logic chk; logic [7:0] pix; } pix_t;
  typedef struct packed { logic v; logic [7:0] d; } rsp_t;

  sync_t             sync_q [$];
  pix_t              pix_q  [$];
  logic [ADDR_W-1:0] addr_q [$];

  int n_cmp = 0;
  int n_bad = 0;
  bit track = 1'b0;
  bit watch_req = 1'b0;
  int tb_out = 0;
  int n_acc = 0;
  int n_req_cycles = 0;
  int lat = 3;
  rsp_t pipe [8] = '{default: '0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix_of(input int h, input int v);
    return 8'((v / 2) * SRC_W + h / 2);
  endfunction

  // VRAM model: in-order returns, data = address[7:0], latency lat cycles.
  always begin
    logic       acc;
    logic [7:0] d;
    @(negedge clk);
    acc = o_req && i_gnt && nreset;
    d   = o_addr[7:0];
    @(posedge clk);
    #1;
    for (int i = 7; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0]  = '{acc, d};
    i_rvalid = pipe[lat-1].v;
    i_rdata  = pipe[lat-1].d;
  end

  // Monitor: all outputs sampled on the falling edge.
  sync_t s_exp;
  pix_t  p_exp;
  always @(negedge clk) begin
    if (!nreset) begin
      tb_out = 0;
    end else if (track) begin
      if (sync_q.size() >= 3) begin
        s_exp = sync_q.pop_front();
        check("sync_hs_vs_de", {29'd0, o_hs, o_vs, o_de}, {29'd0, s_exp});
      end
      if (o_de) begin
        check("pix_queue_has_entry", 32'(pix_q.size() > 0), 32'd1);
        if (pix_q.size() > 0) begin
          p_exp = pix_q.pop_front();
          if (p_exp.chk) check("pixel", 32'(o_pixel), 32'(p_exp.pix));
        end
      end else begin
        check("pixel_blank", 32'(o_pixel), 32'd0);
      end
      if (tb_out == MAX_OUT) check("req_at_max_outstanding", 32'(o_req), 32'd0);
      if (o_req && i_gnt) begin
        n_acc++;
        check("req_expected", 32'(addr_q.size() > 0), 32'd1);
        if (addr_q.size() > 0) check("req_addr", 32'(o_addr), 32'(addr_q.pop_front()));
      end
      tb_out = tb_out + ((o_req && i_gnt) ? 1 : 0) - ((i_rvalid && tb_out > 0) ? 1 : 0);
      if (watch_req && o_req) n_req_cycles++;
    end
  end

  task automatic cyc(input logic hs, input logic vs, input logic de, input int h, input int v,
                     input logic frame, input logic chk);
    @(posedge clk);
    #1;
    i_hs    = hs;
    i_vs    = vs;
    i_de    = de;
    i_h     = de ? 12'(h) : 12'd0;
    i_v     = de ? 12'(v) : 12'd0;
    i_frame = frame;
    if (track) begin
      sync_q.push_back('{hs, vs, de});
      if (de) pix_q.push_back('{chk, pix_of(h, v)});
    end
  endtask

  task automatic idle_cycles(input int n, input logic vs);
    for (int i = 0; i < n; i++) cyc(1'b1, vs, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // One output line: 640 active pixels then 160 blanking cycles with a 96-cycle hsync.
  task automatic run_line(input int v, input bit chk, input int fetch_row);
    if (fetch_row >= 0) begin
      for (int k = 0; k < SRC_W; k++) addr_q.push_back(ADDR_W'(fetch_row * SRC_W + k));
    end
    for (int x = 0; x < 640; x++) cyc(1'b1, 1'b1, 1'b1, x, v, 1'b0, chk);
    for (int x = 0; x < 160; x++) cyc(!(x >= 16 && x < 112), 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    nreset  = 1'b1;
    i_hs    = 1'b1;
    i_vs    = 1'b1;
    i_de    = 1'b0;
    i_frame = 1'b0;
    i_h     = '0;
    i_v     = '0;
    i_gnt   = 1'b1;
    #5 nreset = 1'b0;

    // Reset held mid-frame with DE active on line 100.
    for (int x = 0; x < 8; x++) cyc(1'b1, 1'b1, 1'b1, 200 + x, 100, 1'b0, 1'b0);
    @(negedge clk);
    check("reset_o_req", 32'(o_req), 32'd0);
    check("reset_o_addr", 32'(o_addr), 32'd0);
    check("reset_o_de", 32'(o_de), 32'd0);
    check("reset_o_hs", 32'(o_hs), 32'd1);
    check("reset_o_vs", 32'(o_vs), 32'd1);
    check("reset_o_pixel", 32'(o_pixel), 32'd0);
    check("reset_o_underrun", 32'(o_underrun), 32'd0);

    idle_cycles(1, 1'b1);
    nreset = 1'b1;
    track  = 1'b1;

    // Vertical sync, then start-of-frame: source line 0 into buffer 0.
    idle_cycles(10, 1'b0);
    idle_cycles(5, 1'b1);
    for (int k = 0; k < SRC_W; k++) addr_q.push_back(ADDR_W'(k));
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    idle_cycles(700, 1'b1);
    check("fetch_line0_requests", 32'(n_acc), 32'd320);

    // Longer read latency from here on so the outstanding limit is reached.
    lat = 6;
    run_line(0, 1'b1, 1);
    run_line(1, 1'b1, -1);
    check("no_fetch_on_odd_line", 32'(n_acc), 32'd640);
    run_line(2, 1'b1, 2);
    run_line(3, 1'b1, -1);
    check("underrun_clear", 32'(o_underrun), 32'd0);

    // Stall the grant across the next trigger.
    i_gnt = 1'b0;
    fork
      begin
        repeat (2000) @(posedge clk);
        #1 i_gnt = 1'b1;
      end
    join_none
    run_line(4, 1'b1, 3);
    run_line(5, 1'b1, -1);
    check("underrun_before_late_trigger", 32'(o_underrun), 32'd0);
    run_line(6, 1'b0, -1);
    check("underrun_set", 32'(o_underrun), 32'd1);
    run_line(7, 1'b0, -1);
    check("fetch_line3_requests", 32'(n_acc), 32'd1280);

    // Last source line: nothing left to prefetch.
    watch_req = 1'b1;
    run_line(478, 1'b0, -1);
    run_line(479, 1'b0, -1);
    idle_cycles(20, 1'b1);
    watch_req = 1'b0;
    check("no_req_end_of_frame", 32'(n_req_cycles), 32'd0);
    check("underrun_sticky", 32'(o_underrun), 32'd1);
    check("addr_queue_drained", 32'(addr_q.size()), 32'd0);
    check("pix_queue_drained", 32'(pix_q.size()), 32'd0);
    track = 1'b0;

    nreset = 1'b0;
    @(negedge clk);
    check("underrun_cleared_by_reset", 32'(o_underrun), 32'd0);
    check("reset2_o_hs", 32'(o_hs), 32'd1);
    idle_cycles(2, 1'b1);
    nreset = 1'b1;
    idle_cycles(2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
